// File: rtl/game_pkg.sv
// Shared types and constants for the keypad guessing-game round controller.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_KEY = 3'd2,
      ST_CHECK    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Reserved nibble code for a blanked 7-segment digit.
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/round_timer.sv
// Per-guess timeout counter: clears on request, counts while enabled and
// flags expiry once it has reached TIMEOUT_CYCLES-1.
module round_timer #(
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == CNT_LAST);

   // Next count: clear wins, then count up, holding at the expiry value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/guess_game_ctrl.sv
// Multi-round, multi-try guessing-game controller: latches LFSR targets,
// judges keypad guesses with a per-guess timeout and drives display/motor.
module guess_game_ctrl
   import game_pkg::*;
#(
   parameter int KEY_W          = 4,
   parameter int MAX_TRIES      = 3,
   parameter int ROUNDS         = 4,
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int SCORE_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [KEY_W-1:0] random,
   input  logic [KEY_W-1:0] key_value,
   input  logic             key_valid,
   output logic             motor_en,
   output logic             hit,
   output logic             miss,
   output logic             game_over,
   output logic [3:0]       digit3,
   output logic [3:0]       digit2,
   output logic [3:0]       digit1,
   output logic [3:0]       digit0
);

   localparam int SUM_W = ((SCORE_W > 4) ? SCORE_W : 4) + 1;
   localparam logic [3:0]         TRIES_INIT = 4'(MAX_TRIES);
   localparam logic [3:0]         ROUND_LAST = 4'(ROUNDS);
   localparam logic [SUM_W-1:0]   SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});

   state_t              state_q, state_d;
   logic [3:0]          round_q, round_d;
   logic [3:0]          tries_q, tries_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [KEY_W-1:0]    target_q, target_d;
   logic [KEY_W-1:0]    guess_q, guess_d;
   logic                timed_out_q, timed_out_d;
   logic                key_prev_q;
   logic                motor_en_q, motor_en_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic                game_over_q, game_over_d;
   logic [3:0]          digit3_q, digit2_q, digit1_q, digit0_q;
   logic [3:0]          digit3_d, digit2_d, digit1_d, digit0_d;

   logic                key_edge;
   logic                timer_clear;
   logic                timer_en;
   logic                timer_expired;
   logic                round_over;
   logic [SUM_W-1:0]    score_sum;
   logic [SCORE_W+7:0]  score_ext;

   round_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_round_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   assign key_edge  = key_valid & ~key_prev_q;
   assign score_sum = SUM_W'(score_q) + SUM_W'(tries_q);

   // Next-state and datapath decisions; result pulses and display are
   // computed from the next values so everything lands in the same cycle.
   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      tries_d     = tries_q;
      score_d     = score_q;
      target_d    = target_q;
      guess_d     = guess_q;
      timed_out_d = timed_out_q;
      motor_en_d  = 1'b0;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      timer_clear = 1'b1;
      timer_en    = 1'b0;
      round_over  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (restart) begin
               state_d    = ST_LOAD;
               round_d    = 4'd1;
               score_d    = {SCORE_W{1'b0}};
               tries_d    = TRIES_INIT;
               motor_en_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            target_d = random;
            state_d  = ST_WAIT_KEY;
         end
         ST_WAIT_KEY: begin
            timer_clear = 1'b0;
            timer_en    = 1'b1;
            // A real key edge takes priority over a simultaneous expiry.
            if (key_edge) begin
               guess_d     = key_value;
               timed_out_d = 1'b0;
               state_d     = ST_CHECK;
            end else if (timer_expired) begin
               timed_out_d = 1'b1;
               state_d     = ST_CHECK;
            end else begin
               state_d = ST_WAIT_KEY;
            end
         end
         ST_CHECK: begin
            if (!timed_out_q && (guess_q == target_q)) begin
               hit_d      = 1'b1;
               round_over = 1'b1;
               if (score_sum > SCORE_MAX) begin
                  score_d = {SCORE_W{1'b1}};
               end else begin
                  score_d = score_sum[SCORE_W-1:0];
               end
            end else begin
               miss_d     = 1'b1;
               tries_d    = (tries_q != 4'd0) ? (tries_q - 4'd1) : 4'd0;
               round_over = (tries_q <= 4'd1);
            end
            if (round_over) begin
               if (round_q >= ROUND_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_LOAD;
                  round_d    = round_q + 4'd1;
                  tries_d    = TRIES_INIT;
                  motor_en_d = 1'b1;
               end
            end else begin
               state_d = ST_WAIT_KEY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      game_over_d = (state_d == ST_DONE);
      digit3_d    = round_d;
      digit2_d    = tries_d;
      digit1_d    = score_ext[7:4];
      digit0_d    = score_ext[3:0];
   end

   assign score_ext = {8'h00, score_d};

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         round_q     <= 4'd0;
         tries_q     <= 4'd0;
         score_q     <= {SCORE_W{1'b0}};
         target_q    <= {KEY_W{1'b0}};
         guess_q     <= {KEY_W{1'b0}};
         timed_out_q <= 1'b0;
         key_prev_q  <= 1'b0;
         motor_en_q  <= 1'b0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         game_over_q <= 1'b0;
         digit3_q    <= 4'd0;
         digit2_q    <= 4'd0;
         digit1_q    <= 4'd0;
         digit0_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         tries_q     <= tries_d;
         score_q     <= score_d;
         target_q    <= target_d;
         guess_q     <= guess_d;
         timed_out_q <= timed_out_d;
         key_prev_q  <= key_valid;
         motor_en_q  <= motor_en_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         game_over_q <= game_over_d;
         digit3_q    <= digit3_d;
         digit2_q    <= digit2_d;
         digit1_q    <= digit1_d;
         digit0_q    <= digit0_d;
      end
   end

   assign motor_en  = motor_en_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign game_over = game_over_q;
   assign digit3    = digit3_q;
   assign digit2    = digit2_q;
   assign digit1    = digit1_q;
   assign digit0    = digit0_q;

endmodule
